// File: rtl/mc_control_fsm_if.sv
// Control/handshake bundle between the multicycle control FSM (master)
// and the 16-bit MIPS datapath plus unified memory (slave).
interface mc_control_fsm_if;
    logic [3:0] Opcode;
    logic       Zero;
    logic       Mem_Ready;
    logic       Mem_Req;
    logic       Mem_Write;
    logic       IorD;
    logic       IR_Write;
    logic       PC_Write;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic       SignExtend_En;
    logic       RegWrite;
    logic       RegDst;
    logic       MemToReg;
    logic       Illegal;
    logic       Bus_Error;
    logic       Halted;

    modport master (
        input  Opcode, Zero, Mem_Ready,
        output Mem_Req, Mem_Write, IorD, IR_Write, PC_Write, PCSrc, ALUSrcA,
               ALUSrcB, ALUOp, SignExtend_En, RegWrite, RegDst, MemToReg,
               Illegal, Bus_Error, Halted
    );

    modport slave (
        output Opcode, Zero, Mem_Ready,
        input  Mem_Req, Mem_Write, IorD, IR_Write, PC_Write, PCSrc, ALUSrcA,
               ALUSrcB, ALUOp, SignExtend_En, RegWrite, RegDst, MemToReg,
               Illegal, Bus_Error, Halted
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle control unit for the 16-bit MIPS datapath: sequences
// fetch/decode/execute/memory/writeback and guards memory with a watchdog.
module mc_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    mc_control_fsm_if.master  bus
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC   = 4'd2;
    localparam logic [3:0] S_WB_ALU = 4'd3;
    localparam logic [3:0] S_ADDR   = 4'd4;
    localparam logic [3:0] S_MEM_RD = 4'd5;
    localparam logic [3:0] S_WB_MEM = 4'd6;
    localparam logic [3:0] S_MEM_WR = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_HALT   = 4'd10;

    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_BEQ  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    logic [3:0] r_state;
    logic [7:0] r_wd_cnt;
    logic       r_bus_error;

    logic [3:0] w_state_next;
    logic       w_mem_state;
    logic       w_timeout;
    logic [7:0] w_wd_inc;

    logic       w_mem_req, w_mem_write, w_iord, w_ir_write, w_pc_write;
    logic [1:0] w_pcsrc, w_alusrcb;
    logic       w_alusrca, w_sext, w_regwrite, w_regdst, w_memtoreg;
    logic       w_illegal, w_halted;
    logic [2:0] w_aluop;

    // A timeout fires on the unready cycle whose count would reach the limit;
    // Mem_Ready in that same cycle takes precedence.
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_wd_inc    = r_wd_cnt + 8'd1;
    assign w_timeout   = w_mem_state && !bus.Mem_Ready && (w_wd_inc >= TIMEOUT_C);

    // Next-state selection
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (bus.Mem_Ready)  w_state_next = S_DECODE;
                else if (w_timeout) w_state_next = S_HALT;
                else                w_state_next = S_FETCH;
            end
            S_DECODE: begin
                case (bus.Opcode)
                    4'b0000, 4'b0001, 4'b0010, 4'b0011, OP_ADDI: w_state_next = S_EXEC;
                    OP_LW, OP_SW: w_state_next = S_ADDR;
                    OP_BEQ:       w_state_next = S_BRANCH;
                    OP_J:         w_state_next = S_JUMP;
                    OP_HALT:      w_state_next = S_HALT;
                    default:      w_state_next = S_FETCH;
                endcase
            end
            S_EXEC:   w_state_next = S_WB_ALU;
            S_WB_ALU: w_state_next = S_FETCH;
            S_ADDR:   w_state_next = (bus.Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (bus.Mem_Ready)  w_state_next = S_WB_MEM;
                else if (w_timeout) w_state_next = S_HALT;
                else                w_state_next = S_MEM_RD;
            end
            S_WB_MEM: w_state_next = S_FETCH;
            S_MEM_WR: begin
                if (bus.Mem_Ready)  w_state_next = S_FETCH;
                else if (w_timeout) w_state_next = S_HALT;
                else                w_state_next = S_MEM_WR;
            end
            S_BRANCH: w_state_next = S_FETCH;
            S_JUMP:   w_state_next = S_FETCH;
            S_HALT:   w_state_next = S_HALT;
            default:  w_state_next = S_FETCH;
        endcase
    end

    // State, watchdog counter and sticky bus error
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_FETCH;
            r_wd_cnt    <= 8'd0;
            r_bus_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_timeout) r_bus_error <= 1'b1;
            else           r_bus_error <= r_bus_error;
            if (w_mem_state && !bus.Mem_Ready && (w_state_next == r_state))
                r_wd_cnt <= w_wd_inc;
            else
                r_wd_cnt <= 8'd0;
        end
    end

    // Control decode; everything is low during Reset
    always_comb begin
        w_mem_req = 1'b0; w_mem_write = 1'b0; w_iord = 1'b0;
        w_ir_write = 1'b0; w_pc_write = 1'b0; w_pcsrc = 2'b00;
        w_alusrca = 1'b0; w_alusrcb = 2'b00; w_aluop = 3'b000;
        w_sext = 1'b0; w_regwrite = 1'b0; w_regdst = 1'b0;
        w_memtoreg = 1'b0; w_illegal = 1'b0; w_halted = 1'b0;
        if (!Reset) begin
            case (r_state)
                S_FETCH: begin
                    w_mem_req = 1'b1;
                    if (bus.Mem_Ready) begin
                        w_ir_write = 1'b1;
                        w_pc_write = 1'b1;
                        w_alusrcb  = 2'b01;
                    end else begin
                        w_ir_write = 1'b0;
                    end
                end
                S_DECODE: begin
                    w_alusrcb = 2'b10;
                    w_sext    = 1'b1;
                    if (bus.Opcode > OP_J && bus.Opcode != OP_HALT) w_illegal = 1'b1;
                    else                                             w_illegal = 1'b0;
                end
                S_EXEC: begin
                    w_alusrca = 1'b1;
                    if (bus.Opcode == OP_ADDI) begin
                        w_alusrcb = 2'b10;
                        w_sext    = 1'b1;
                    end else begin
                        w_aluop = bus.Opcode[2:0];
                    end
                end
                S_WB_ALU: begin
                    w_regwrite = 1'b1;
                    w_regdst   = (bus.Opcode != OP_ADDI);
                end
                S_ADDR: begin
                    w_alusrca = 1'b1;
                    w_alusrcb = 2'b10;
                    w_sext    = 1'b1;
                end
                S_MEM_RD: begin
                    w_mem_req = 1'b1;
                    w_iord    = 1'b1;
                end
                S_WB_MEM: begin
                    w_regwrite = 1'b1;
                    w_memtoreg = 1'b1;
                end
                S_MEM_WR: begin
                    w_mem_req   = 1'b1;
                    w_mem_write = 1'b1;
                    w_iord      = 1'b1;
                end
                S_BRANCH: begin
                    w_alusrca  = 1'b1;
                    w_aluop    = 3'b001;
                    w_pcsrc    = 2'b01;
                    w_pc_write = bus.Zero;
                end
                S_JUMP: begin
                    w_pcsrc    = 2'b10;
                    w_pc_write = 1'b1;
                end
                S_HALT:  w_halted = 1'b1;
                default: w_halted = 1'b0;
            endcase
        end else begin
            w_mem_req = 1'b0;
        end
    end

    assign bus.Mem_Req       = w_mem_req;
    assign bus.Mem_Write     = w_mem_write;
    assign bus.IorD          = w_iord;
    assign bus.IR_Write      = w_ir_write;
    assign bus.PC_Write      = w_pc_write;
    assign bus.PCSrc         = w_pcsrc;
    assign bus.ALUSrcA       = w_alusrca;
    assign bus.ALUSrcB       = w_alusrcb;
    assign bus.ALUOp         = w_aluop;
    assign bus.SignExtend_En = w_sext;
    assign bus.RegWrite      = w_regwrite;
    assign bus.RegDst        = w_regdst;
    assign bus.MemToReg      = w_memtoreg;
    assign bus.Illegal       = w_illegal;
    assign bus.Bus_Error     = r_bus_error & ~Reset;
    assign bus.Halted        = w_halted;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: a per-instruction cycle model builds the expected
// output trace together with its stimulus; one process compares every cycle.
module tb_mc_control_fsm;
    localparam int T = 15;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic       sext;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       illegal;
        logic       bus_error;
        logic       halted;
    } outs_t;

    typedef struct {
        logic       rst;
        logic       mr;
        logic       z;
        logic [3:0] op;
        outs_t      exp;
    } rec_t;

    logic clk;
    logic reset;
    mc_control_fsm_if bus();

    mc_control_fsm #(.MEM_TIMEOUT(T)) dut (.Clk(clk), .Reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    rec_t       q[$];
    rec_t       cur;
    bit         cur_valid;
    logic [3:0] cur_op;
    bit         bus_err_m;
    int         n_checks;
    int         n_pass;
    int         cyc;

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic rst, input logic mr, input logic z,
                        input logic [3:0] op, input outs_t e);
        rec_t r;
        r.rst = rst; r.mr = mr; r.z = z; r.op = op; r.exp = e;
        q.push_back(r);
    endtask

    task automatic halt_then_reset();
        outs_t e;
        int n;
        n = $urandom_range(20, 24);
        for (int i = 0; i < n; i++) begin
            e = '0; e.halted = 1'b1; e.bus_error = bus_err_m;
            push(1'b0, rnd(), rnd(), cur_op, e);
        end
        push(1'b1, rnd(), rnd(), cur_op, '0);
        bus_err_m = 1'b0;
    endtask

    // w unready cycles, carrying base outputs; reports a watchdog expiry
    task automatic mem_wait(input outs_t base, input logic [3:0] op, input int w, output bit to);
        to = 1'b0;
        for (int i = 0; i < w; i++) begin
            push(1'b0, 1'b0, rnd(), op, base);
            if (i + 1 == T) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic instr(input logic [3:0] op, input int fw, input int mw, input logic z);
        outs_t e;
        bit    to;
        e = '0; e.mem_req = 1'b1;
        mem_wait(e, cur_op, fw, to);
        if (to) begin
            bus_err_m = 1'b1;
            halt_then_reset();
            return;
        end
        e.ir_write = 1'b1; e.pc_write = 1'b1; e.alusrcb = 2'b01;
        push(1'b0, 1'b1, rnd(), cur_op, e);
        cur_op = op;
        e = '0; e.alusrcb = 2'b10; e.sext = 1'b1;
        e.illegal = (op >= 4'd9 && op <= 4'd14);
        push(1'b0, rnd(), rnd(), op, e);
        if (op <= 4'd3) begin
            e = '0; e.alusrca = 1'b1; e.aluop = op[2:0];
            push(1'b0, rnd(), rnd(), op, e);
            e = '0; e.regwrite = 1'b1; e.regdst = 1'b1;
            push(1'b0, rnd(), rnd(), op, e);
        end else if (op == 4'd4) begin
            e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10; e.sext = 1'b1;
            push(1'b0, rnd(), rnd(), op, e);
            e = '0; e.regwrite = 1'b1;
            push(1'b0, rnd(), rnd(), op, e);
        end else if (op == 4'd5 || op == 4'd6) begin
            e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10; e.sext = 1'b1;
            push(1'b0, rnd(), rnd(), op, e);
            e = '0; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_write = (op == 4'd6);
            mem_wait(e, op, mw, to);
            if (to) begin
                bus_err_m = 1'b1;
                halt_then_reset();
                return;
            end
            push(1'b0, 1'b1, rnd(), op, e);
            if (op == 4'd5) begin
                e = '0; e.regwrite = 1'b1; e.memtoreg = 1'b1;
                push(1'b0, rnd(), rnd(), op, e);
            end
        end else if (op == 4'd7) begin
            e = '0; e.alusrca = 1'b1; e.aluop = 3'b001; e.pcsrc = 2'b01; e.pc_write = z;
            push(1'b0, rnd(), z, op, e);
        end else if (op == 4'd8) begin
            e = '0; e.pcsrc = 2'b10; e.pc_write = 1'b1;
            push(1'b0, rnd(), rnd(), op, e);
        end else if (op == 4'd15) begin
            halt_then_reset();
        end
    endtask

    task automatic pin(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, want);
    endtask

    // Per-cycle comparison of the whole control vector
    always @(negedge clk) begin
        if (cur_valid) begin
            outs_t d;
            d.mem_req = bus.Mem_Req;   d.mem_write = bus.Mem_Write; d.iord = bus.IorD;
            d.ir_write = bus.IR_Write; d.pc_write = bus.PC_Write;   d.pcsrc = bus.PCSrc;
            d.alusrca = bus.ALUSrcA;   d.alusrcb = bus.ALUSrcB;     d.aluop = bus.ALUOp;
            d.sext = bus.SignExtend_En; d.regwrite = bus.RegWrite;  d.regdst = bus.RegDst;
            d.memtoreg = bus.MemToReg; d.illegal = bus.Illegal;     d.bus_error = bus.Bus_Error;
            d.halted = bus.Halted;
            n_checks++;
            if (d === cur.exp) n_pass++;
            else $display("FAIL ctrl cycle %0d op=%0h: got %05h, expected %05h",
                          cyc, cur.op, d, cur.exp);
        end
    end

    initial begin
        int s;
        reset = 1'b1; bus.Mem_Ready = 1'b0; bus.Zero = 1'b0; bus.Opcode = 4'd0;
        cur_valid = 1'b0; cur_op = 4'd0; bus_err_m = 1'b0;
        n_checks = 0; n_pass = 0; cyc = 0;

        push(1'b1, 1'b0, 1'b0, cur_op, '0);
        push(1'b1, 1'b1, 1'b0, cur_op, '0);

        s = q.size(); instr(4'h0, 0, 0, 1'b0);
        pin("add_len", q.size() - s, 4);
        pin("fetch_done_vec", int'(q[s].exp), 32'h98400);
        pin("decode_vec", int'(q[s+1].exp), 32'h00840);
        pin("add_wb_vec", int'(q[s+3].exp), 32'h00030);
        s = q.size(); instr(4'h4, 0, 0, 1'b0);
        pin("addi_len", q.size() - s, 4);
        s = q.size(); instr(4'h5, 0, 3, 1'b0);
        pin("lw_wait3_len", q.size() - s, 8);
        s = q.size(); instr(4'h6, 0, 0, 1'b0);
        pin("sw_len", q.size() - s, 4);
        s = q.size(); instr(4'h7, 0, 0, 1'b1);
        pin("beq_len", q.size() - s, 3);
        instr(4'h7, 0, 0, 1'b0);
        s = q.size(); instr(4'h8, 0, 0, 1'b0);
        pin("j_len", q.size() - s, 3);
        instr(4'hA, 0, 0, 1'b0);
        instr(4'hF, 0, 0, 1'b0);
        s = q.size(); instr(4'h1, T, 0, 1'b0);
        pin("fetch_timeout_err", int'(q[s+T].exp.bus_error), 1);
        s = q.size(); instr(4'h0, T - 1, 0, 1'b0);
        pin("fetch_just_in_time_len", q.size() - s, T - 1 + 4);
        instr(4'h5, 0, T, 1'b0);
        instr(4'h6, 1, T - 1, 1'b0);
        instr(4'h6, 0, T, 1'b0);

        for (int k = 0; k < 160; k++) begin
            logic [3:0] op;
            int fw, mw;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0 && op == 4'hF) op = 4'h0;
            fw = ($urandom_range(0, 19) == 0) ? $urandom_range(12, 16) : $urandom_range(0, 3);
            mw = ($urandom_range(0, 19) == 0) ? $urandom_range(12, 16) : $urandom_range(0, 3);
            instr(op, fw, mw, rnd());
        end

        foreach (q[i]) begin
            @(posedge clk); #1;
            reset = q[i].rst; bus.Mem_Ready = q[i].mr; bus.Zero = q[i].z; bus.Opcode = q[i].op;
            cur = q[i]; cur_valid = 1'b1; cyc = i;
        end
        @(posedge clk); #1;
        cur_valid = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
